uart_rx_sampler: RTL and testbench
==================================

Name: uart_rx_sampler

Overview:
- Oversampling UART receiver; the stage directly upstream of the echo/transmit path.
- Deserialises the RXD line into bytes and presents each byte with a one-cycle valid strobe and a framing-error flag.
- Runs on the system clock and advances only on a baud-rate enable tick from the baud-rate generator (OVERSAMPLE ticks per bit), so there is no second clock domain.

Parameters:
- OVERSAMPLE, 16, rx_tick pulses per bit period; must be even and ≥ 4.
- DATA_BITS, 8, data bits per frame, sent LSB first.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rx_tick  input  1  one-clk enable pulse at OVERSAMPLE × baud rate.
- RXD  input  1  serial line, asynchronous, idle high.
- RX_DATA  output  DATA_BITS  last good received byte.
- rx_valid  output  1  one-clk pulse when RX_DATA is updated.
- frame_err  output  1  one-clk pulse when the stop bit samples low.
- rx_busy  output  1  high from start detect until return to IDLE.

Behaviour:
- Interface: one clock, clk; reset_n is asynchronous and active-low.
- Reset values:
  - RX_DATA = 0; rx_valid = 0; frame_err = 0; rx_busy = 0.
  - Both RXD synchroniser flops = 1; tick_cnt = 0; bit_cnt = 0; state = WAIT_HIGH.
- RXD passes through a 2-FF synchroniser (rxd_s). All decisions use rxd_s.
- tick_cnt and bit_cnt change only on cycles where rx_tick = 1; other cycles hold all state.
- States:
  - WAIT_HIGH: on rx_tick with rxd_s = 1, go to IDLE. Ensures a reset or a break in mid-frame never produces a false start.
  - IDLE: on rx_tick with rxd_s = 0, set tick_cnt = 0, rx_busy = 1, go to START.
  - START: tick_cnt++ each tick. At tick_cnt = OVERSAMPLE/2-1 (mid start bit):
    - rxd_s = 1: glitch; go to IDLE, rx_busy = 0, no strobe.
    - rxd_s = 0: tick_cnt = 0, bit_cnt = 0, go to DATA.
  - DATA: at tick_cnt = OVERSAMPLE-1 (mid bit):
    - Shift rxd_s into the MSB of the shift register (right shift); tick_cnt = 0; bit_cnt++.
    - After DATA_BITS samples, go to STOP (or PARITY when the option is enabled).
  - STOP: at tick_cnt = OVERSAMPLE-1, sample:
    - rxd_s = 1: on the next clk, RX_DATA <= shift register and rx_valid = 1 for exactly one clk; go to IDLE.
    - rxd_s = 0: frame_err = 1 for one clk; RX_DATA unchanged; go to WAIT_HIGH.
- rx_busy deasserts on the same clk that IDLE or WAIT_HIGH is entered.
- Latency: rx_valid rises 1 clk after the mid-stop-bit sampling tick.
- rx_valid and frame_err are never asserted together.
- Back-to-back frames: a start edge seen on the first tick in IDLE is accepted, so no idle gap is required beyond one stop bit.
- No flow control: the consumer must capture RX_DATA on rx_valid. RX_DATA is stable until the next rx_valid.
- Asynchronous reset mid-frame aborts immediately. A partial frame never produces rx_valid; reception resumes only after the line is seen high.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, one bit period long, sampled at tick_cnt = OVERSAMPLE-1.
  - Check is even parity: XOR of the data bits and the parity bit must be 0.
  - Adds output port parity_err (1 bit, reset 0), pulsed for one clk together with rx_valid when the check fails. RX_DATA is still updated.
- Undefined: no PARITY state and no parity_err port; frame is start + DATA_BITS + stop.

Test Plan:
- Reset sequence: hold reset_n = 0 for 100 ns with RXD = 1, release, then send 0xD6 as 0,0,1,1,0,1,0,1,1,1 (start, LSB-first data, stop), OVERSAMPLE = 16, rx_tick every 4 clk → single rx_valid pulse, RX_DATA = 0xD6, frame_err never set, rx_busy low afterwards.
- Back-to-back frames: 0x55 then 0xAA with no idle gap → two rx_valid pulses exactly 10 bit periods apart, RX_DATA = 0x55 then 0xAA.
- Glitch rejection: RXD low for 5 rx_ticks then high → no rx_valid, no frame_err, state back in IDLE; a following 0x3C frame is received correctly.
- Framing error: send 0xFF with the stop bit driven 0, then hold RXD low for 3 bit times, then high → one frame_err pulse, RX_DATA keeps its previous value, no new frame until RXD returns high, next 0x81 frame received.
- Reset mid-frame: assert reset_n low during data bit 4 of 0xA5, release while RXD is still low → all outputs 0, no rx_valid for the aborted frame; the next full 0x12 frame gives RX_DATA = 0x12.
- Parity (UART_RX_PARITY_EN defined):
  - 0x07 with parity bit 1 → rx_valid, parity_err = 0.
  - 0x07 with parity bit 0 → rx_valid and parity_err pulse on the same clk, RX_DATA = 0x07.

Source files
------------

// File: rtl/uart_rx_sampler_if.sv
// Receive-side output bundle of the UART sampler: received byte, strobes and busy flag.
// Latency: none (pure signal grouping).
// Backpressure: none; the consumer must capture RX_DATA on rx_valid. Adds parity_err under UART_RX_PARITY_EN.
interface uart_rx_sampler_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] RX_DATA;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 rx_busy;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;
`endif

`ifdef UART_RX_PARITY_EN
    modport master (output RX_DATA, output rx_valid, output frame_err, output rx_busy, output parity_err);
    modport slave  (input  RX_DATA, input  rx_valid, input  frame_err, input  rx_busy, input  parity_err);
`else
    modport master (output RX_DATA, output rx_valid, output frame_err, output rx_busy);
    modport slave  (input  RX_DATA, input  rx_valid, input  frame_err, input  rx_busy);
`endif
endinterface

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver: 2-FF synchronised RXD, mid-bit sampling, byte out with framing check.
// Latency: rx_valid/frame_err pulse 1 clk after the mid-stop-bit sampling tick.
// Backpressure: none; RX_DATA holds until the next rx_valid. UART_RX_PARITY_EN adds an even-parity bit and parity_err.
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_tick,
    input  logic              RXD,
    uart_rx_sampler_if.master rx
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state, state_nxt;
    logic                 rxd_meta, rxd_s;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, frame_err_q;
    logic                 busy, stop_tick, good_stop, bad_stop;
    logic                 full_mid;
`ifdef UART_RX_PARITY_EN
    logic                 par_fail, parity_err_q;
`endif

    assign full_mid = (tick_cnt == FULL_LAST);

    // Two-flop synchroniser for the asynchronous line; idle level is high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= RXD;
            rxd_s    <= rxd_meta;
        end
    end

    // State register; reset lands in WAIT_HIGH so a low line never looks like a start bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= WAIT_HIGH;
        else          state <= state_nxt;
    end

    // Next-state logic; transitions happen only on baud ticks
    always_comb begin
        state_nxt = state;
        if (rx_tick) begin
            case (state)
                WAIT_HIGH: if (rxd_s)  state_nxt = IDLE;
                IDLE:      if (!rxd_s) state_nxt = START;
                START:     if (tick_cnt == HALF_LAST) state_nxt = rxd_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
                DATA:      if (full_mid && bit_cnt == BITS_LAST) state_nxt = PARITY;
                PARITY:    if (full_mid) state_nxt = STOP;
`else
                DATA:      if (full_mid && bit_cnt == BITS_LAST) state_nxt = STOP;
`endif
                STOP:      if (full_mid) state_nxt = rxd_s ? IDLE : WAIT_HIGH;
                default:   state_nxt = WAIT_HIGH;
            endcase
        end
    end

    // Output decode: busy follows the state, stop-bit outcome drives next-cycle strobes
    always_comb begin
        busy      = (state != WAIT_HIGH) && (state != IDLE);
        stop_tick = rx_tick && (state == STOP) && full_mid;
        good_stop = stop_tick && rxd_s;
        bad_stop  = stop_tick && !rxd_s;
    end

    // Bit timing counters, shift register and registered output strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_fail     <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_valid_q  <= good_stop;
            frame_err_q <= bad_stop;
            if (good_stop) rx_data_q <= shreg;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= good_stop && par_fail;
`endif
            if (rx_tick) begin
                case (state)
                    START: begin
                        if (tick_cnt == HALF_LAST) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    DATA: begin
                        if (full_mid) begin
                            shreg    <= {rxd_s, shreg[DATA_BITS-1:1]};
                            tick_cnt <= '0;
                            bit_cnt  <= bit_cnt + BW'(1);
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (full_mid) begin
                            par_fail <= (^shreg) ^ rxd_s;
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
`endif
                    STOP: begin
                        if (full_mid) tick_cnt <= '0;
                        else          tick_cnt <= tick_cnt + TW'(1);
                    end
                    default: tick_cnt <= '0;
                endcase
            end
        end
    end

    assign rx.RX_DATA    = rx_data_q;
    assign rx.rx_valid   = rx_valid_q;
    assign rx.frame_err  = frame_err_q;
    assign rx.rx_busy    = busy;
`ifdef UART_RX_PARITY_EN
    assign rx.parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: frames are driven bit-accurately, expectations queued at send time.
// Latency: outputs sampled on the falling clock edge.
// Backpressure: none; every strobe pops one scoreboard entry.
module tb_uart_rx_sampler;
    localparam int OS       = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = OS * TICK_DIV;

    typedef struct {
        logic       is_ferr;
        logic [7:0] data;
        logic       par;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rx_tick = 1'b0;
    logic RXD = 1'b1;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int n_perr = 0;
    int cyc = 0;
    int tick_div = 0;
    logic [7:0] last_good = 8'h00;
    exp_t exp_q[$];
    int vtimes[$];

    uart_rx_sampler_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_sampler #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx_tick (rx_tick),
        .RXD     (RXD),
        .rx      (rx_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Baud tick: one clk in every TICK_DIV
    initial begin
        forever begin
            @(negedge clk);
            tick_div = (tick_div + 1) % TICK_DIV;
            rx_tick  = (tick_div == 0);
        end
    end

    // Output monitor: every strobe is matched against the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        logic exp_perr;
        if (rx_if.rx_valid || rx_if.frame_err) begin
            checks++;
            if (rx_if.rx_valid && rx_if.frame_err) begin
                errors++;
                $display("FAIL strobe_overlap: rx_valid=%0b frame_err=%0b, required not both", rx_if.rx_valid, rx_if.frame_err);
            end
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: rx_valid=%0b frame_err=%0b data=%02h, required none", rx_if.rx_valid, rx_if.frame_err, rx_if.RX_DATA);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (rx_if.frame_err !== e.is_ferr) begin
                    errors++;
                    $display("FAIL strobe_kind: frame_err=%0b, required %0b", rx_if.frame_err, e.is_ferr);
                end
                if (rx_if.rx_valid) begin
                    n_valid++;
                    vtimes.push_back(cyc);
                    checks++;
                    if (rx_if.RX_DATA !== e.data) begin
                        errors++;
                        $display("FAIL rx_data: got %02h, required %02h", rx_if.RX_DATA, e.data);
                    end
`ifdef UART_RX_PARITY_EN
                    exp_perr = (^e.data) ^ e.par;
                    checks++;
                    if (rx_if.parity_err !== exp_perr) begin
                        errors++;
                        $display("FAIL parity_err: got %0b, required %0b", rx_if.parity_err, exp_perr);
                    end
`else
                    exp_perr = 1'b0;
`endif
                    if (exp_perr) n_perr++;
                    last_good = e.data;
                end
                if (rx_if.frame_err) begin
                    n_ferr++;
                    checks++;
                    if (rx_if.RX_DATA !== last_good) begin
                        errors++;
                        $display("FAIL ferr_hold: RX_DATA=%02h, required %02h", rx_if.RX_DATA, last_good);
                    end
                end
            end
        end
    end

    task automatic hold_line(input logic v, input int nbits);
        RXD = v;
        repeat (nbits * BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        exp_t e;
        e.is_ferr = !stop_b;
        e.data    = d;
        e.par     = par_b;
        exp_q.push_back(e);
        hold_line(1'b0, 1);
        for (int i = 0; i < 8; i++) hold_line(d[i], 1);
`ifdef UART_RX_PARITY_EN
        hold_line(par_b, 1);
`endif
        hold_line(stop_b, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if (rx_if.RX_DATA !== 8'h00 || rx_if.rx_valid !== 1'b0 || rx_if.frame_err !== 1'b0 || rx_if.rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: data=%02h valid=%0b ferr=%0b busy=%0b, required all 0", tag, rx_if.RX_DATA, rx_if.rx_valid, rx_if.frame_err, rx_if.rx_busy);
        end
    endtask

    task automatic check_drained(input string tag, input logic [7:0] d);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d pending, required 0", tag, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (rx_if.RX_DATA !== d) begin
            errors++;
            $display("FAIL %s_data: got %02h, required %02h", tag, rx_if.RX_DATA, d);
        end
        checks++;
        if (rx_if.rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy: got %0b, required 0", tag, rx_if.rx_busy);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        int nv;
        reset_n = 1'b0;
        RXD = 1'b1;
        #100;
        check_outputs_zero("reset_state");
        @(negedge clk);
        reset_n = 1'b1;
        hold_line(1'b1, 2);
        nv = n_valid;
        e.is_ferr = 1'b0;
        e.data = 8'hD6;
        e.par = ^8'hD6;
        exp_q.push_back(e);
        hold_line(1'b0, 1);
        checks++;
        if (rx_if.rx_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_frame: got %0b, required 1", rx_if.rx_busy);
        end
        for (int i = 0; i < 8; i++) hold_line(e.data[i], 1);
`ifdef UART_RX_PARITY_EN
        hold_line(e.par, 1);
`endif
        hold_line(1'b1, 1);
        check_drained("reset_frame", 8'hD6);
        checks++;
        if (n_valid != nv + 1 || n_ferr != 0) begin
            errors++;
            $display("FAIL reset_frame_counts: valid=%0d ferr=%0d, required %0d and 0", n_valid - nv, n_ferr, 1);
        end
    endtask

    task automatic test_back_to_back();
        vtimes.delete();
        send_frame(8'h55, 1'b1, ^8'h55);
        send_frame(8'hAA, 1'b1, ^8'hAA);
        hold_line(1'b1, 1);
        check_drained("b2b", 8'hAA);
        checks++;
        if (vtimes.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d pulses, required 2", vtimes.size());
        end else begin
            checks++;
`ifdef UART_RX_PARITY_EN
            if (vtimes[1] - vtimes[0] != 11 * BIT_CLKS) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d clk, required %0d", vtimes[1] - vtimes[0], 11 * BIT_CLKS);
            end
`else
            if (vtimes[1] - vtimes[0] != 10 * BIT_CLKS) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d clk, required %0d", vtimes[1] - vtimes[0], 10 * BIT_CLKS);
            end
`endif
        end
    endtask

    task automatic test_glitch();
        int nv, nf;
        nv = n_valid;
        nf = n_ferr;
        RXD = 1'b0;
        repeat (5 * TICK_DIV) @(negedge clk);
        hold_line(1'b1, 2);
        checks++;
        if (n_valid != nv || n_ferr != nf || rx_if.rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch: valid=%0d ferr=%0d busy=%0b, required 0 0 0", n_valid - nv, n_ferr - nf, rx_if.rx_busy);
        end
        send_frame(8'h3C, 1'b1, ^8'h3C);
        hold_line(1'b1, 1);
        check_drained("glitch_next", 8'h3C);
    endtask

    task automatic test_framing();
        int nv, nf;
        nv = n_valid;
        nf = n_ferr;
        send_frame(8'hFF, 1'b0, ^8'hFF);
        hold_line(1'b0, 3);
        checks++;
        if (n_ferr != nf + 1 || n_valid != nv) begin
            errors++;
            $display("FAIL ferr_count: ferr=%0d valid=%0d, required 1 and 0", n_ferr - nf, n_valid - nv);
        end
        checks++;
        if (rx_if.RX_DATA !== 8'h3C || rx_if.rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL ferr_state: data=%02h busy=%0b, required 3c and 0", rx_if.RX_DATA, rx_if.rx_busy);
        end
        hold_line(1'b1, 1);
        send_frame(8'h81, 1'b1, ^8'h81);
        hold_line(1'b1, 1);
        check_drained("ferr_next", 8'h81);
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int nv;
        d = 8'hA5;
        nv = n_valid;
        hold_line(1'b0, 1);
        for (int i = 0; i < 4; i++) hold_line(d[i], 1);
        RXD = d[4];
        repeat (BIT_CLKS / 2) @(negedge clk);
        reset_n = 1'b0;
        last_good = 8'h00;
        #1;
        check_outputs_zero("mid_reset_state");
        #20;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        checks++;
        if (rx_if.rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_busy: got %0b, required 0", rx_if.rx_busy);
        end
        hold_line(1'b1, 2);
        checks++;
        if (n_valid != nv) begin
            errors++;
            $display("FAIL mid_reset_abort: got %0d pulses, required 0", n_valid - nv);
        end
        send_frame(8'h12, 1'b1, ^8'h12);
        hold_line(1'b1, 1);
        check_drained("mid_reset_next", 8'h12);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int np;
        np = n_perr;
        send_frame(8'h07, 1'b1, 1'b1);
        hold_line(1'b1, 1);
        check_drained("parity_good", 8'h07);
        checks++;
        if (n_perr != np) begin
            errors++;
            $display("FAIL parity_good_count: got %0d, required 0", n_perr - np);
        end
        send_frame(8'h07, 1'b1, 1'b0);
        hold_line(1'b1, 1);
        check_drained("parity_bad", 8'h07);
        checks++;
        if (n_perr != np + 1) begin
            errors++;
            $display("FAIL parity_bad_count: got %0d, required 1", n_perr - np);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain: %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
